// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA widths, text-cell geometry and the timing bundle
//                that travels alongside each pixel through the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int HC_W    = 11;  // hcount/vcount width
  localparam int COLOR_W = 12;  // 4:4:4 RGB
  localparam int CHAR_W  = 8;   // glyph width in pixels
  localparam int CHAR_H  = 16;  // glyph height in pixels

  // Raster position and sync/blank flags of one pixel
  typedef struct packed {
    logic [HC_W-1:0] hcount;
    logic [HC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

  // Font rows are stored MSB-first: pixel 0 of the cell is bit 7
  function automatic logic glyph_bit(input logic [CHAR_W-1:0] pixels,
                                     input logic [2:0]        idx);
    return pixels[3'd7 - idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay
//  Description : Fixed-depth register delay line with synchronous reset.
//                Used to carry timing, colour and per-pixel metadata past
//                the external glyph fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift the delay line one stage per clock; reset clears every stage
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/draw_rect_text.sv
`default_nettype none
// ============================================================================
//  Module      : draw_rect_text
//  Description : Overlays a COLS x ROWS grid of 8x16 text cells on the VGA
//                stream. Stage 1 produces the glyph fetch address, the
//                external RAM/ROM returns the font row FETCH_LAT cycles
//                later, and a final stage composites it with a blinking
//                cursor cell. Total latency is FETCH_LAT + 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_rect_text
  import vga_pkg::*;
#(
  parameter int                 COLS         = 16,
  parameter int                 ROWS         = 16,
  parameter int                 FETCH_LAT    = 2,
  parameter logic [COLOR_W-1:0] FG_COLOR     = 12'h000,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h0a0,
  parameter int                 TRANSPARENT  = 0,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [HC_W-1:0]    hcount_in,
  input  logic [HC_W-1:0]    vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [COLOR_W-1:0] rgb_in,
  input  logic [HC_W-1:0]    xpos,
  input  logic [HC_W-1:0]    ypos,
  input  logic               cursor_en,
  input  logic [5:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  input  logic [CHAR_W-1:0]  char_pixels,
  output logic [HC_W-1:0]    hcount_out,
  output logic [HC_W-1:0]    vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [COLOR_W-1:0] rgb_out,
  output logic [5:0]         char_col,
  output logic [4:0]         char_row,
  output logic [3:0]         char_line
);

  // Grid extent in pixels, held at 12 bits so xpos_l + extent cannot wrap
  localparam logic [11:0] c_GRID_W     = 12'(CHAR_W * COLS);
  localparam logic [11:0] c_GRID_H     = 12'(CHAR_H * ROWS);
  localparam logic [7:0]  c_BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam int          c_META_W     = 5;  // {in_grid, idx[2:0], cursor_hit}
  localparam int          c_TR_W       = TIMING_W + COLOR_W;

  // ---------------------------------------------------------------------
  // Frame-level state: latched grid origin and cursor blink
  // ---------------------------------------------------------------------
  logic            r_vblnk_prev;
  logic [HC_W-1:0] r_xpos_l;
  logic [HC_W-1:0] r_ypos_l;
  logic [7:0]      r_frame_cnt;
  logic            r_blink_on;
  logic            w_vblnk_rise;

  // A vblnk already high when reset releases counts as a rising edge
  assign w_vblnk_rise = vblnk_in & ~r_vblnk_prev;

  // Latch the origin and advance the blink counter once per frame
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_xpos_l     <= '0;
      r_ypos_l     <= '0;
      r_frame_cnt  <= '0;
      r_blink_on   <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (w_vblnk_rise) begin
        r_xpos_l <= xpos;
        r_ypos_l <= ypos;
        if (r_frame_cnt == c_BLINK_LAST) begin
          r_frame_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: grid hit test and glyph fetch address
  // ---------------------------------------------------------------------
  logic [11:0] w_h;
  logic [11:0] w_v;
  logic [11:0] w_xl;
  logic [11:0] w_yl;
  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_in_grid;
  logic [5:0]  w_col;
  logic [4:0]  w_row;
  logic        w_cur_hit;

  assign w_h  = {1'b0, hcount_in};
  assign w_v  = {1'b0, vcount_in};
  assign w_xl = {1'b0, r_xpos_l};
  assign w_yl = {1'b0, r_ypos_l};
  assign w_dx = w_h - w_xl;
  assign w_dy = w_v - w_yl;

  // Once h >= xl the 12-bit difference is exact, so comparing it to the
  // extent is the same as h < xl + extent and never wraps past 2047
  assign w_in_x    = (w_h >= w_xl) && (w_dx < c_GRID_W);
  assign w_in_y    = (w_v >= w_yl) && (w_dy < c_GRID_H);
  assign w_in_grid = w_in_x && w_in_y;

  assign w_col = w_dx[8:3];
  assign w_row = w_dy[8:4];

  // In-grid implies col < COLS and row < ROWS, so an out-of-range cursor
  // can never match a cell
  assign w_cur_hit = cursor_en && r_blink_on && w_in_grid &&
                     (w_col == cursor_col) && (w_row == cursor_row);

  logic [c_META_W-1:0] r_s1_meta;

  // Register fetch address (zero outside the grid) and per-pixel metadata
  always_ff @(posedge pclk) begin
    if (rst) begin
      char_col  <= '0;
      char_row  <= '0;
      char_line <= '0;
      r_s1_meta <= '0;
    end else begin
      char_col  <= w_in_grid ? w_col      : 6'd0;
      char_row  <= w_in_grid ? w_row      : 5'd0;
      char_line <= w_in_grid ? w_dy[3:0]  : 4'd0;
      r_s1_meta <= {w_in_grid, w_dx[2:0], w_cur_hit};
    end
  end

  // ---------------------------------------------------------------------
  // Delay lines aligning metadata, timing and colour with char_pixels
  // ---------------------------------------------------------------------
  logic [c_META_W-1:0] w_meta_d;
  logic [c_TR_W-1:0]   w_tr_in;
  logic [c_TR_W-1:0]   w_tr_d;
  timing_t             w_tim_in;
  timing_t             w_tim_d;
  logic [COLOR_W-1:0]  w_rgb_d;

  assign w_tim_in = '{hcount: hcount_in, vcount: vcount_in,
                      hsync: hsync_in, vsync: vsync_in,
                      hblnk: hblnk_in, vblnk: vblnk_in};
  assign w_tr_in  = {w_tim_in, rgb_in};

  vga_delay #(
    .WIDTH (c_META_W),
    .DEPTH (FETCH_LAT)
  ) u_meta_dly (
    .pclk (pclk),
    .rst  (rst),
    .din  (r_s1_meta),
    .dout (w_meta_d)
  );

  vga_delay #(
    .WIDTH (c_TR_W),
    .DEPTH (FETCH_LAT + 1)
  ) u_timing_dly (
    .pclk (pclk),
    .rst  (rst),
    .din  (w_tr_in),
    .dout (w_tr_d)
  );

  assign {w_tim_d, w_rgb_d} = w_tr_d;

  // ---------------------------------------------------------------------
  // Final stage: composite glyph, cursor and background
  // ---------------------------------------------------------------------
  logic               w_m_in_grid;
  logic [2:0]         w_m_idx;
  logic               w_m_hit;
  logic               w_bit;
  logic [COLOR_W-1:0] w_bg;
  logic [COLOR_W-1:0] w_rgb_nxt;

  assign {w_m_in_grid, w_m_idx, w_m_hit} = w_meta_d;
  assign w_bit = glyph_bit(char_pixels, w_m_idx);
  assign w_bg  = (TRANSPARENT != 0) ? w_rgb_d : BG_COLOR;

  // Choose the output colour; the cursor cell swaps foreground and background
  always_comb begin
    w_rgb_nxt = w_rgb_d;
    if (w_m_in_grid && !w_tim_d.hblnk && !w_tim_d.vblnk) begin
      if (w_m_hit) begin
        w_rgb_nxt = w_bit ? BG_COLOR : FG_COLOR;
      end else begin
        w_rgb_nxt = w_bit ? FG_COLOR : w_bg;
      end
    end
  end

  // Output register for colour and the matching timing signals
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= w_tim_d.hcount;
      vcount_out <= w_tim_d.vcount;
      hsync_out  <= w_tim_d.hsync;
      vsync_out  <= w_tim_d.vsync;
      hblnk_out  <= w_tim_d.hblnk;
      vblnk_out  <= w_tim_d.vblnk;
      rgb_out    <= w_rgb_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/draw_rect_text.md
DRAW_RECT_TEXT -- requirements
Module: draw_rect_text

Interface
REQ-001 Parameter COLS, default 16: text grid width in character cells (1..64).
REQ-002 Parameter ROWS, default 16: text grid height in character cells (1..32).
REQ-003 Parameter FETCH_LAT, default 2: cycles from char_col/char_row/char_line output to valid char_pixels input (1..4).
REQ-004 Parameter FG_COLOR, default 12'h000: glyph foreground colour.
REQ-005 Parameter BG_COLOR, default 12'h0a0: cell background colour.
REQ-006 Parameter TRANSPARENT, default 0: when 1, background pixels show rgb_in instead of BG_COLOR.
REQ-007 Parameter BLINK_FRAMES, default 30: frames per cursor blink half-period (1..255).
REQ-008 pclk  in  1  pixel clock; all logic is on its rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 hcount_in, vcount_in  in  11 each  pixel position; hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing.
REQ-011 rgb_in  in  12  upstream pixel colour.
REQ-012 xpos, ypos  in  11 each  grid top-left corner, any pixel value, no alignment requirement.
REQ-013 cursor_en  in  1; cursor_col  in  6; cursor_row  in  5  cursor cell.
REQ-014 char_pixels  in  8  font row from external text RAM + font ROM; bit 7 = leftmost pixel.
REQ-015 hcount_out, vcount_out  out  11; hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  timing delayed by L.
REQ-016 rgb_out  out  12  composited pixel.
REQ-017 char_col  out  6; char_row  out  5; char_line  out  4  glyph fetch address.

Function
REQ-018 Total latency L = FETCH_LAT + 2 cycles from any input to the matching timing outputs and rgb_out.
REQ-019 Stage 1 registers char_col = (hcount_in - xpos_l) >> 3, char_row = (vcount_in - ypos_l) >> 4, char_line = (vcount_in - ypos_l)[3:0].
REQ-020 Difference arithmetic is 12-bit unsigned. In-grid = hcount_in >= xpos_l, hcount_in < xpos_l + 8*COLS, and the same for vcount_in/ypos_l with 16*ROWS; grid overrunning 2047 is clipped, never wrapped.
REQ-021 Out-of-grid: char_col, char_row and char_line are 0.
REQ-022 In-grid flag, pixel bit index (hcount_in - xpos_l)[2:0] and cursor-hit are delayed alongside the fetch so they align with char_pixels.
REQ-023 Selected glyph bit = char_pixels[7 - index].
REQ-024 In-grid, not blanked: bit 1 -> FG_COLOR; bit 0 -> BG_COLOR, or delayed rgb_in when TRANSPARENT = 1.
REQ-025 Cursor cell: cursor_en = 1, blink_on = 1 and cell = (cursor_col, cursor_row). FG and BG are swapped for that cell; transparent background becomes FG_COLOR.
REQ-026 Out-of-grid, or hblnk/vblnk set at that stage: rgb_out = rgb_in delayed by L.
REQ-027 Rising edge of vblnk_in: xpos_l/ypos_l load xpos/ypos, and frame_cnt increments. Mid-frame xpos/ypos changes take effect only at that edge.
REQ-028 frame_cnt reaching BLINK_FRAMES-1 wraps to 0 and toggles blink_on on the same edge.
REQ-029 Cursor coordinates outside COLS/ROWS never produce a cursor hit.

Reset
REQ-030 rst high: all outputs, every pipeline stage, xpos_l, ypos_l, frame_cnt and blink_on are 0.
REQ-031 After rst falls, outputs are 0 until the pipeline refills (L cycles).
REQ-032 The vblnk edge detector's previous-value register resets to 0, so a vblnk_in already high at release counts as a rising edge.

Structure
REQ-033 Package vga_pkg holds HC_W = 11, COLOR_W = 12, CHAR_W = 8, CHAR_H = 16 and the timing-bundle struct.
REQ-034 Sub-module vga_delay (parameters WIDTH, DEPTH; synchronous reset) delays the timing bundle and rgb_in.

Verification
REQ-035 xpos = 100, ypos = 50, char_pixels = 8'h80 constant: pixel (100,50) -> FG_COLOR at output cycle +4; (101,50) -> BG_COLOR; (99,50) -> rgb_in.
REQ-036 hcount_in = 117, vcount_in = 83, xpos = 100, ypos = 50 -> char_col = 2, char_row = 2, char_line = 1 one cycle later.
REQ-037 TRANSPARENT = 1, char_pixels = 0, rgb_in = 12'hf00 -> rgb_out = 12'hf00 over the whole grid.
REQ-038 cursor at (0,0), BLINK_FRAMES = 2, six vblnk pulses -> cell (0,0) inverted in frames 2-3, normal in frames 0-1 and 4-5.
REQ-039 xpos changed 0 -> 40 mid-frame -> grid moves only after the next vblnk rise; hcount = 2040 with xpos = 2000 is in-grid and hcount = 5 is out-of-grid (no wrap).
REQ-040 rst asserted mid-line for 3 cycles -> all outputs 0; first valid output L cycles after release.
